// File: rtl/matmul_lane_scheduler_if.sv
// Handshake bundle between the layer sequencer, the dot-product engine bank
// and the result buffer for matmul_lane_scheduler.
// slave  : the scheduler itself
// master : the surrounding environment (sequencer, engines, buffer)
interface matmul_lane_scheduler_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4
);
    logic                                start;
    logic                                abort;
    logic [ADDR_WIDTH-1:0]               cfg_out_count;
    logic [ADDR_WIDTH-1:0]               cfg_vec_len;
    logic                                busy;
    logic                                done;
    logic [NUM_LANES-1:0]                dp_start;
    logic [NUM_LANES-1:0]                dp_done;
    logic [NUM_LANES*ADDR_WIDTH-1:0]     dp_weight_base_addr;
    logic [NUM_LANES*2*DATA_WIDTH-1:0]   dp_result;
    logic                                result_wr_en;
    logic [ADDR_WIDTH-1:0]               result_wr_addr;
    logic [2*DATA_WIDTH-1:0]             result_wr_data;

    modport master (
        output start, abort, cfg_out_count, cfg_vec_len, dp_done, dp_result,
        input  busy, done, dp_start, dp_weight_base_addr,
               result_wr_en, result_wr_addr, result_wr_data
    );

    modport slave (
        input  start, abort, cfg_out_count, cfg_vec_len, dp_done, dp_result,
        output busy, done, dp_start, dp_weight_base_addr,
               result_wr_en, result_wr_addr, result_wr_data
    );
endinterface

// File: rtl/matmul_lane_scheduler.sv
// matmul_lane_scheduler: issues one output neuron per dot-product engine in
// passes of NUM_LANES, collects the per-lane results and serialises them to
// the result buffer in lane order.
// Optional macro RELU_EN: when defined, negative results are written as 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; config is sampled on an accepted start
// S_ISSUE | one cycle: start active lanes, publish their weight row bases
// S_WAIT  | collect dp_done/dp_result from active lanes into capture regs
// S_DRAIN | one result-buffer write per cycle, ascending active lanes
// S_FIN   | last pass drained; emit the done pulse
//
// Every output is registered from the decision made in the current state, so
// dp_start/base address appear the cycle after ISSUE, writes the cycle after
// each DRAIN cycle, and done the cycle after FIN. busy alone is registered
// from the next state so it tracks state != IDLE exactly.
module matmul_lane_scheduler #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    matmul_lane_scheduler_if.slave  bus
);
    localparam int RW = 2 * DATA_WIDTH;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    // wide enough that base_idx + lane never wraps in the compares
    localparam int CW = ADDR_WIDTH + LW + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           out_cnt_q, out_cnt_d;
    logic [ADDR_WIDTH-1:0]           stride_q, stride_d;
    logic [ADDR_WIDTH-1:0]           base_idx_q, base_idx_d;
    logic [NUM_LANES-1:0]            active_q, active_d;
    logic [NUM_LANES-1:0]            flag_q, flag_d;
    logic [RW-1:0]                   cap_q [NUM_LANES];
    logic [RW-1:0]                   cap_d [NUM_LANES];
    logic [LW-1:0]                   lane_q, lane_d;

    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [NUM_LANES-1:0]            dp_start_q, dp_start_d;
    logic [NUM_LANES*ADDR_WIDTH-1:0] dp_base_q, dp_base_d;
    logic                            wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]           wr_addr_q, wr_addr_d;
    logic [RW-1:0]                   wr_data_q, wr_data_d;

    logic                            last_lane;
    logic [RW-1:0]                   drain_val;

    // Next-state, datapath updates and registered-output values.
    always_comb begin
        state_d    = state_q;
        out_cnt_d  = out_cnt_q;
        stride_d   = stride_q;
        base_idx_d = base_idx_q;
        active_d   = active_q;
        flag_d     = flag_q;
        cap_d      = cap_q;
        lane_d     = lane_q;
        done_d     = 1'b0;
        dp_start_d = '0;
        dp_base_d  = dp_base_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        last_lane  = 1'b0;
        drain_val  = cap_q[lane_q];

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    out_cnt_d  = bus.cfg_out_count;
                    stride_d   = bus.cfg_vec_len;
                    base_idx_d = '0;
                    flag_d     = '0;
                    lane_d     = '0;
                    state_d    = (bus.cfg_out_count == '0) ? S_FIN : S_ISSUE;
                end
            end

            S_ISSUE: begin
                // base addresses are refreshed for every lane; only active
                // lanes get a start pulse
                for (int l = 0; l < NUM_LANES; l++) begin
                    active_d[l] = (CW'(base_idx_q) + CW'(l)) < CW'(out_cnt_q);
                    dp_base_d[l*ADDR_WIDTH +: ADDR_WIDTH] =
                        (base_idx_q + ADDR_WIDTH'(l)) * stride_q;
                end
                dp_start_d = active_d;
                flag_d     = '0;
                lane_d     = '0;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (bus.dp_done[l] && active_q[l] && !flag_q[l]) begin
                        cap_d[l]  = bus.dp_result[l*RW +: RW];
                        flag_d[l] = 1'b1;
                    end
                end
                if ((flag_d & active_q) == active_q) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
`ifdef RELU_EN
                drain_val = cap_q[lane_q][RW-1] ? '0 : cap_q[lane_q];
`else
                drain_val = cap_q[lane_q];
`endif
                wr_en_d   = 1'b1;
                wr_addr_d = base_idx_q + ADDR_WIDTH'(lane_q);
                wr_data_d = drain_val;
                // active lanes are always a contiguous low group
                last_lane = (lane_q == LW'(NUM_LANES - 1)) ||
                            ((CW'(base_idx_q) + CW'(lane_q) + CW'(1)) >= CW'(out_cnt_q));
                if (last_lane) begin
                    lane_d = '0;
                    if ((CW'(base_idx_q) + CW'(NUM_LANES)) >= CW'(out_cnt_q)) begin
                        state_d = S_FIN;
                    end else begin
                        base_idx_d = base_idx_q + ADDR_WIDTH'(NUM_LANES);
                        flag_d     = '0;
                        state_d    = S_ISSUE;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort wins over everything outside IDLE; progress is dropped
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            flag_d     = '0;
            lane_d     = '0;
            done_d     = 1'b0;
            dp_start_d = '0;
            dp_base_d  = dp_base_q;
            wr_en_d    = 1'b0;
            wr_addr_d  = '0;
            wr_data_d  = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            out_cnt_q  <= '0;
            stride_q   <= '0;
            base_idx_q <= '0;
            active_q   <= '0;
            flag_q     <= '0;
            lane_q     <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                cap_q[l] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dp_start_q <= '0;
            dp_base_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            stride_q   <= stride_d;
            base_idx_q <= base_idx_d;
            active_q   <= active_d;
            flag_q     <= flag_d;
            lane_q     <= lane_d;
            cap_q      <= cap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dp_start_q <= dp_start_d;
            dp_base_q  <= dp_base_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.dp_start            = dp_start_q;
    assign bus.dp_weight_base_addr = dp_base_q;
    assign bus.result_wr_en        = wr_en_q;
    assign bus.result_wr_addr      = wr_addr_q;
    assign bus.result_wr_data      = wr_data_q;
endmodule

// File: tb/tb_matmul_lane_scheduler.sv
// Directed bench for matmul_lane_scheduler with a small engine-bank model.
module tb_matmul_lane_scheduler;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NL = 4;
    localparam int RW = 2 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matmul_lane_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

    matmul_lane_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(NL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // engine model configuration (written by the main sequence only)
    int            eng_delay [NL];
    logic [RW-1:0] eng_tab [NL];
    bit            eng_tab_en = 1'b0;
    bit            eng_force_all = 1'b0;
    int            eng_off = 0;
    int            eng_stride = 1;

    // engine model state and logs (written by the engine process only)
    int                   eng_cnt [NL];
    logic [RW-1:0]        eng_res [NL];
    logic [NL-1:0]        eng_d;
    int                   lane0_done_cyc = 0;
    logic [NL-1:0]        iss_start [$];
    logic [NL*AW-1:0]     iss_base [$];

    // write/done logs (written by the monitor process only)
    int                   wr_cyc [$];
    logic [AW-1:0]        wr_adr [$];
    logic [RW-1:0]        wr_dat [$];
    int                   n_done = 0;
    int                   done_cyc = 0;

    // engine bank: each started lane answers eng_delay cycles later; the
    // result is eng_off + row index unless a fixed table is selected
    initial begin
        for (int l = 0; l < NL; l++) begin
            eng_cnt[l] = 0;
            eng_res[l] = '0;
        end
        bus.dp_done   = '0;
        bus.dp_result = '0;
        forever begin
            @(negedge clk);
            eng_d = '0;
            for (int l = 0; l < NL; l++) begin
                if (eng_cnt[l] > 0) begin
                    eng_cnt[l]--;
                    if (eng_cnt[l] == 0) eng_d[l] = 1'b1;
                end
            end
            if (eng_d[0]) lane0_done_cyc = cyc;
            if (bus.dp_start != '0) begin
                iss_start.push_back(bus.dp_start);
                iss_base.push_back(bus.dp_weight_base_addr);
                for (int l = 0; l < NL; l++) begin
                    if (bus.dp_start[l] || eng_force_all) begin
                        eng_cnt[l] = eng_delay[l];
                        if (eng_tab_en)
                            eng_res[l] = eng_tab[l];
                        else if (bus.dp_start[l])
                            eng_res[l] = RW'(eng_off + int'(bus.dp_weight_base_addr[l*AW +: AW]) / eng_stride);
                        else
                            eng_res[l] = 32'h0BAD_0000;
                    end
                end
            end
            bus.dp_done = eng_d;
            for (int l = 0; l < NL; l++) bus.dp_result[l*RW +: RW] = eng_res[l];
        end
    end

    // result buffer and done monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.result_wr_en === 1'b1) begin
                wr_cyc.push_back(cyc);
                wr_adr.push_back(bus.result_wr_addr);
                wr_dat.push_back(bus.result_wr_data);
            end
            if (bus.done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_start(input int cnt, input int len, output int scyc);
        @(negedge clk);
        bus.start         = 1'b1;
        bus.cfg_out_count = AW'(cnt);
        bus.cfg_vec_len   = AW'(len);
        scyc              = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int base_done, input string tag);
        int k;
        k = 0;
        while (n_done == base_done && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, 64'(n_done - base_done), 64'(1));
    endtask

    initial begin
        int s, b_wr, b_dn, b_is, k, n_at_rst;
        logic [NL*AW-1:0] bv;
        logic [RW-1:0]    exp_neg;

`ifdef RELU_EN
        exp_neg = '0;
`else
        exp_neg = RW'(-5);
`endif
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_out_count = '0;
        bus.cfg_vec_len   = '0;
        for (int l = 0; l < NL; l++) begin
            eng_delay[l] = 3;
            eng_tab[l]   = '0;
        end

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_dp_start", 64'(bus.dp_start), 64'(0));
        chk("rst_base", 64'(bus.dp_weight_base_addr), 64'(0));
        chk("rst_wr_en", 64'(bus.result_wr_en), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // two full passes, results 100+index; a start while busy is ignored
        eng_stride = 8; eng_off = 100;
        b_wr = wr_adr.size(); b_dn = n_done; b_is = iss_start.size();
        do_start(8, 8, s);
        chk("t1_busy", 64'(bus.busy), 64'(1));
        bus.start = 1'b1; bus.cfg_out_count = AW'(1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(b_dn, "t1");
        chk("t1_nwr", 64'(wr_adr.size() - b_wr), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_addr%0d", i), 64'(wr_adr[b_wr+i]), 64'(i));
            chk($sformatf("t1_data%0d", i), 64'(wr_dat[b_wr+i]), 64'(100 + i));
        end
        chk("t1_nissue", 64'(iss_start.size() - b_is), 64'(2));
        chk("t1_start0", 64'(iss_start[b_is]), 64'(4'b1111));
        chk("t1_base0", 64'(iss_base[b_is]), 64'({10'd24, 10'd16, 10'd8, 10'd0}));
        chk("t1_base1", 64'(iss_base[b_is+1]), 64'({10'd56, 10'd48, 10'd40, 10'd32}));
        chk("t1_burst", 64'(wr_cyc[b_wr+3] - wr_cyc[b_wr]), 64'(3));
        chk("t1_done_lat", 64'(done_cyc - wr_cyc[b_wr+7]), 64'(1));
        chk("t1_idle", 64'(bus.busy), 64'(0));

        // partial final pass; every lane is pulsed so lanes 2-3 are stray
        eng_stride = 4; eng_off = 200; eng_force_all = 1'b1;
        b_wr = wr_adr.size(); b_dn = n_done; b_is = iss_start.size();
        do_start(6, 4, s);
        wait_done(b_dn, "t2");
        chk("t2_nwr", 64'(wr_adr.size() - b_wr), 64'(6));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_addr%0d", i), 64'(wr_adr[b_wr+i]), 64'(i));
            chk($sformatf("t2_data%0d", i), 64'(wr_dat[b_wr+i]), 64'(200 + i));
        end
        chk("t2_start1", 64'(iss_start[b_is+1]), 64'(4'b0011));
        bv = iss_base[b_is+1];
        chk("t2_base1_l0", 64'(bv[AW-1:0]), 64'(16));
        chk("t2_base1_l1", 64'(bv[2*AW-1:AW]), 64'(20));
        eng_force_all = 1'b0;

        // zero outputs
        b_wr = wr_adr.size(); b_dn = n_done; b_is = iss_start.size();
        do_start(0, 5, s);
        wait_done(b_dn, "t3");
        chk("t3_done_lat", 64'(done_cyc - s), 64'(2));
        chk("t3_nissue", 64'(iss_start.size() - b_is), 64'(0));
        chk("t3_nwr", 64'(wr_adr.size() - b_wr), 64'(0));

        // staggered completions: lane3, lane1, lane2, then lane0 five later
        eng_stride = 1; eng_off = 50;
        eng_delay[0] = 8; eng_delay[1] = 2; eng_delay[2] = 3; eng_delay[3] = 1;
        b_wr = wr_adr.size(); b_dn = n_done;
        do_start(4, 1, s);
        wait_done(b_dn, "t4");
        chk("t4_nwr", 64'(wr_adr.size() - b_wr), 64'(4));
        chk("t4_first_wr", 64'(wr_cyc[b_wr] - lane0_done_cyc), 64'(2));
        chk("t4_burst", 64'(wr_cyc[b_wr+3] - wr_cyc[b_wr]), 64'(3));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_addr%0d", i), 64'(wr_adr[b_wr+i]), 64'(i));
            chk($sformatf("t4_data%0d", i), 64'(wr_dat[b_wr+i]), 64'(50 + i));
        end

        // abort during WAIT of the first pass, then a clean run
        eng_stride = 8; eng_off = 100;
        for (int l = 0; l < NL; l++) eng_delay[l] = 5;
        b_wr = wr_adr.size(); b_dn = n_done; b_is = iss_start.size();
        do_start(8, 8, s);
        k = 0;
        while (iss_start.size() == b_is && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t5_issue_seen", 64'(iss_start.size() - b_is), 64'(1));
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t5_busy_after_abort", 64'(bus.busy), 64'(0));
        repeat (12) @(negedge clk);
        chk("t5_nwr", 64'(wr_adr.size() - b_wr), 64'(0));
        chk("t5_ndone", 64'(n_done - b_dn), 64'(0));
        chk("t5_nissue", 64'(iss_start.size() - b_is), 64'(1));
        chk("t5_idle", 64'(bus.busy), 64'(0));
        // start together with abort in IDLE is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_out_count = AW'(4);
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("t5_start_abort_busy", 64'(bus.busy), 64'(0));
        b_wr = wr_adr.size(); b_dn = n_done;
        do_start(4, 8, s);
        wait_done(b_dn, "t5b");
        chk("t5b_nwr", 64'(wr_adr.size() - b_wr), 64'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("t5b_data%0d", i), 64'(wr_dat[b_wr+i]), 64'(100 + i));

        // reset in the middle of DRAIN
        eng_tab_en = 1'b1;
        eng_tab[0] = RW'(-5); eng_tab[1] = RW'(7); eng_tab[2] = RW'(9); eng_tab[3] = RW'(11);
        for (int l = 0; l < NL; l++) eng_delay[l] = 2;
        b_wr = wr_adr.size(); b_dn = n_done;
        do_start(4, 1, s);
        k = 0;
        while (wr_adr.size() == b_wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t6_first_wr_seen", 64'(wr_adr.size() > b_wr), 64'(1));
        chk("t6_first_data", 64'(wr_dat[b_wr]), 64'(exp_neg));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(bus.busy), 64'(0));
        chk("t6_rst_done", 64'(bus.done), 64'(0));
        chk("t6_rst_dp_start", 64'(bus.dp_start), 64'(0));
        chk("t6_rst_base", 64'(bus.dp_weight_base_addr), 64'(0));
        chk("t6_rst_wr_en", 64'(bus.result_wr_en), 64'(0));
        chk("t6_rst_wr_addr", 64'(bus.result_wr_addr), 64'(0));
        chk("t6_rst_wr_data", 64'(bus.result_wr_data), 64'(0));
        n_at_rst = wr_adr.size();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_no_more_wr", 64'(wr_adr.size() - n_at_rst), 64'(0));
        chk("t6_no_done", 64'(n_done - b_dn), 64'(0));
        chk("t6_idle", 64'(bus.busy), 64'(0));

        // sign handling of the written value: -5 and +7
        b_wr = wr_adr.size(); b_dn = n_done;
        do_start(2, 1, s);
        wait_done(b_dn, "t7");
        chk("t7_nwr", 64'(wr_adr.size() - b_wr), 64'(2));
        chk("t7_data_neg", 64'(wr_dat[b_wr]), 64'(exp_neg));
        chk("t7_data_pos", 64'(wr_dat[b_wr+1]), 64'(RW'(7)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
